// File: rtl/bram_stream_loader_pkg.sv
// Shared types and helpers for the byte-stream to 32-bit BRAM loader.
// Holds the FSM encoding, word geometry and lane-mask helpers.
package bram_stream_loader_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned LANE_IDX_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ACCESS,
        ST_COMPARE,
        ST_DONE
    } state_e;

    // Filled-lane count (0..4) to per-byte write enable.
    function automatic logic [BYTE_LANES-1:0] lane_mask(input logic [2:0] filled);
        logic [BYTE_LANES-1:0] m;
        case (filled)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [WORD_W-1:0] bit_mask(input logic [BYTE_LANES-1:0] we);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int k = 0; k < int'(BYTE_LANES); k++) begin
            m[8*k +: 8] = {8{we[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/bram_stream_loader_if.sv
// Stream input and BRAM port bundle; master is the loader side.
interface bram_stream_loader_if #(
    parameter int unsigned ADDR_WIDTH = 12
) ();
    logic [7:0]            s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  bram_clken;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [3:0]            bram_we;
    logic [31:0]           bram_wdata;
    logic [31:0]           bram_rdata;

    modport master (
        input  s_data, s_valid, bram_rdata,
        output s_ready, bram_clken, bram_addr, bram_we, bram_wdata
    );

    modport slave (
        output s_data, s_valid, bram_rdata,
        input  s_ready, bram_clken, bram_addr, bram_we, bram_wdata
    );
endinterface

// File: rtl/bram_stream_loader_byte_packer.sv
// Little-endian byte-to-word assembly: lane counter, word register and fill mask.
module bram_stream_loader_byte_packer
    import bram_stream_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [7:0]            data,
    output logic [WORD_W-1:0]     word_c,
    output logic [BYTE_LANES-1:0] mask_c,
    output logic                  full_c
);

    logic [LANE_IDX_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0]     word_q, word_d;

    // Word and mask as they stand including the byte being pushed this cycle.
    always_comb begin
        word_c = word_q;
        for (int k = 0; k < int'(BYTE_LANES); k++) begin
            if (push && (lane_q == LANE_IDX_W'(k))) begin
                word_c[8*k +: 8] = data;
            end
        end
        mask_c = lane_mask(3'(lane_q) + 3'(push));
        full_c = push && (lane_q == LANE_IDX_W'(BYTE_LANES - 1));
    end

    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        if (clr) begin
            lane_d = '0;
            word_d = '0;
        end else if (push) begin
            lane_d = lane_q + LANE_IDX_W'(1);
            word_d = word_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/bram_stream_loader.sv
// Packs a byte stream into 32-bit BRAM words (write or read-back verify),
// keeping a running checksum and reporting done/error.
module bram_stream_loader
    import bram_stream_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LEN_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  verify,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  byte_count,
    bram_stream_loader_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [WORD_W-1:0]     checksum
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  verify_q, verify_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [BYTE_LANES-1:0] mask_q, mask_d;
    logic                  s_ready_q, s_ready_d;
    logic                  clken_q, clken_d;
    logic [BYTE_LANES-1:0] we_q, we_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [WORD_W-1:0]     checksum_q, checksum_d;

    logic                  accept_c, last_c, mismatch_c, pk_clr;
    logic [WORD_W-1:0]     pk_word;
    logic [BYTE_LANES-1:0] pk_mask;
    logic                  pk_full;

    assign accept_c   = bus.s_valid & s_ready_q;
    assign last_c     = (remaining_q == LEN_WIDTH'(1));
    assign mismatch_c = |((bus.bram_rdata ^ word_q) & bit_mask(mask_q));

    bram_stream_loader_byte_packer u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (pk_clr),
        .push   (accept_c),
        .data   (bus.s_data),
        .word_c (pk_word),
        .mask_c (pk_mask),
        .full_c (pk_full)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        verify_d    = verify_q;
        word_d      = word_q;
        mask_d      = mask_q;
        bram_addr_d = bram_addr_q;
        clken_d     = 1'b0;
        we_d        = '0;
        wdata_d     = '0;
        error_d     = error_q;
        checksum_d  = checksum_q;
        pk_clr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = byte_count;
                    verify_d    = verify;
                    error_d     = 1'b0;
                    checksum_d  = '0;
                    pk_clr      = 1'b1;
                    state_d     = (byte_count == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept_c) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (pk_full || last_c) begin
                        word_d      = pk_word;
                        mask_d      = pk_mask;
                        pk_clr      = 1'b1;
                        clken_d     = 1'b1;
                        bram_addr_d = addr_q;
                        we_d        = verify_q ? '0 : pk_mask;
                        wdata_d     = verify_q ? '0 : pk_word;
                        state_d     = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                checksum_d = checksum_q + word_q;
                addr_d     = addr_q + ADDR_WIDTH'(1);
                if (verify_q) begin
                    state_d = ST_COMPARE;
                end else begin
                    state_d = (remaining_q == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COMPARE: begin
                if (mismatch_c) begin
                    error_d = 1'b1;
                end
                state_d = (remaining_q == '0) ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort suppresses any pending access; an access already on the port still counts.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            clken_d = 1'b0;
            we_d    = '0;
            wdata_d = '0;
            error_d = error_q;
            pk_clr  = 1'b1;
        end

        s_ready_d = (state_d == ST_COLLECT);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            verify_q    <= 1'b0;
            word_q      <= '0;
            mask_q      <= '0;
            s_ready_q   <= 1'b0;
            clken_q     <= 1'b0;
            we_q        <= '0;
            wdata_q     <= '0;
            bram_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            verify_q    <= verify_d;
            word_q      <= word_d;
            mask_q      <= mask_d;
            s_ready_q   <= s_ready_d;
            clken_q     <= clken_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            bram_addr_q <= bram_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            checksum_q  <= checksum_d;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.bram_clken = clken_q;
    assign bus.bram_addr  = bram_addr_q;
    assign bus.bram_we    = we_q;
    assign bus.bram_wdata = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign checksum       = checksum_q;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed bench for bram_stream_loader with a byte-enabled BRAM model.
module tb_bram_stream_loader;

    localparam int unsigned AW = 12;
    localparam int unsigned LW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          verify = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] byte_count = '0;
    logic          busy, done, error;
    logic [31:0]   checksum;

    bram_stream_loader_if #(.ADDR_WIDTH(AW)) bus ();

    bram_stream_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .verify     (verify),
        .base_addr  (base_addr),
        .byte_count (byte_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // BRAM model: byte-enabled write, registered read.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.bram_clken) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.bram_we[k]) mem[bus.bram_addr][8*k +: 8] <= bus.bram_wdata[8*k +: 8];
            end
            bus.bram_rdata <= mem[bus.bram_addr];
        end
    end

    int          acc_n = 0;
    int          wr_n = 0;
    int          done_n = 0;
    logic [AW-1:0] acc_addr[$];
    logic [3:0]  acc_we[$];
    logic [31:0] acc_wd[$];

    always @(posedge clk) begin
        if (bus.bram_clken) begin
            acc_n++;
            acc_addr.push_back(bus.bram_addr);
            acc_we.push_back(bus.bram_we);
            acc_wd.push_back(bus.bram_wdata);
            if (bus.bram_we != 4'b0000) wr_n++;
        end
        if (done) done_n++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic v, input logic [AW-1:0] a, input logic [LW-1:0] c);
        verify = v;
        base_addr = a;
        byte_count = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte from a negedge and return at the negedge after the transfer.
    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.s_data = b;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(bus.s_ready), 32'd1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data = 8'hEE;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0, w0;
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 32'(bus.s_ready), 0);
        chk("rst_clken", 32'(bus.bram_clken), 0);
        chk("rst_we", 32'(bus.bram_we), 0);
        chk("rst_addr", 32'(bus.bram_addr), 0);
        chk("rst_wdata", bus.bram_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_checksum", checksum, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: eight bytes written as two full words
        a0 = acc_n; d0 = done_n;
        kick(1'b0, 12'h010, 14'd8);
        chk("t1_busy", 32'(busy), 1);
        for (int i = 1; i <= 8; i++) send(8'(i));
        wait_done();
        chk("t1_acc_cnt", 32'(acc_n - a0), 2);
        chk("t1_addr0", 32'(acc_addr[a0]), 32'h010);
        chk("t1_wd0", acc_wd[a0], 32'h04030201);
        chk("t1_we0", 32'(acc_we[a0]), 32'hF);
        chk("t1_addr1", 32'(acc_addr[a0+1]), 32'h011);
        chk("t1_wd1", acc_wd[a0+1], 32'h08070605);
        chk("t1_we1", 32'(acc_we[a0+1]), 32'hF);
        chk("t1_checksum", checksum, 32'h0C0A0806);
        @(negedge clk);
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_done_cnt", 32'(done_n - d0), 1);

        // 2: address wrap and 2-byte tail
        a0 = acc_n;
        kick(1'b0, 12'hFFF, 14'd6);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
        wait_done();
        chk("t2_acc_cnt", 32'(acc_n - a0), 2);
        chk("t2_addr0", 32'(acc_addr[a0]), 32'hFFF);
        chk("t2_wd0", acc_wd[a0], 32'hDDCCBBAA);
        chk("t2_we0", 32'(acc_we[a0]), 32'hF);
        chk("t2_addr1", 32'(acc_addr[a0+1]), 32'h000);
        chk("t2_wd1", acc_wd[a0+1], 32'h0000FFEE);
        chk("t2_we1", 32'(acc_we[a0+1]), 32'h3);
        chk("t2_checksum", checksum, 32'hDDCDBB98);
        @(negedge clk);

        // 3: verify matching data, then with one corrupted byte
        a0 = acc_n; d0 = done_n; w0 = wr_n;
        kick(1'b1, 12'h010, 14'd8);
        for (int i = 1; i <= 8; i++) send(8'(i));
        wait_done();
        chk("t3_error", 32'(error), 0);
        chk("t3_acc_cnt", 32'(acc_n - a0), 2);
        chk("t3_checksum", checksum, 32'h0C0A0806);
        @(negedge clk);
        chk("t3_done_cnt", 32'(done_n - d0), 1);
        d0 = done_n;
        kick(1'b1, 12'h010, 14'd8);
        for (int i = 1; i <= 8; i++) send((i == 5) ? 8'h55 : 8'(i));
        wait_done();
        chk("t3b_error", 32'(error), 1);
        chk("t3b_checksum", checksum, 32'h0C0A0856);
        @(negedge clk);
        chk("t3_no_writes", 32'(wr_n - w0), 0);
        chk("t3b_done_cnt", 32'(done_n - d0), 1);

        // 4: zero-length request
        a0 = acc_n;
        kick(1'b0, 12'h200, 14'd0);
        chk("t4_done_next", 32'(done), 1);
        chk("t4_error_clr", 32'(error), 0);
        chk("t4_checksum", checksum, 0);
        @(negedge clk);
        chk("t4_done_off", 32'(done), 0);
        chk("t4_busy_off", 32'(busy), 0);
        chk("t4_no_access", 32'(acc_n - a0), 0);

        // 5a: stalled stream with 3-cycle gaps
        a0 = acc_n;
        kick(1'b0, 12'h020, 14'd4);
        send(8'h11); repeat (3) @(negedge clk);
        send(8'h22); repeat (3) @(negedge clk);
        send(8'h33); repeat (3) @(negedge clk);
        send(8'h44);
        wait_done();
        chk("t5a_acc_cnt", 32'(acc_n - a0), 1);
        chk("t5a_addr", 32'(acc_addr[a0]), 32'h020);
        chk("t5a_wd", acc_wd[a0], 32'h44332211);
        @(negedge clk);

        // 5b: start while busy is ignored; abort after five bytes
        a0 = acc_n; d0 = done_n;
        kick(1'b0, 12'h030, 14'd8);
        send(8'h91); send(8'h92);
        kick(1'b1, 12'h100, 14'd0);
        chk("t5b_still_busy", 32'(busy), 1);
        send(8'h93); send(8'h94); send(8'h95);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5b_acc_cnt", 32'(acc_n - a0), 1);
        chk("t5b_addr", 32'(acc_addr[a0]), 32'h030);
        chk("t5b_wd", acc_wd[a0], 32'h94939291);
        chk("t5b_no_done", 32'(done_n - d0), 0);
        chk("t5b_busy", 32'(busy), 0);
        chk("t5b_s_ready", 32'(bus.s_ready), 0);
        chk("t5b_checksum", checksum, 32'h94939291);

        // 6: async reset mid-collect, then a fresh run from lane 0
        kick(1'b0, 12'h040, 14'd8);
        send(8'h71); send(8'h72);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_s_ready", 32'(bus.s_ready), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_addr", 32'(bus.bram_addr), 0);
        chk("t6_checksum", checksum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a0 = acc_n;
        kick(1'b0, 12'h050, 14'd4);
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        wait_done();
        chk("t6_acc_cnt", 32'(acc_n - a0), 1);
        chk("t6_addr_new", 32'(acc_addr[a0]), 32'h050);
        chk("t6_wd", acc_wd[a0], 32'hA4A3A2A1);
        chk("t6_we", 32'(acc_we[a0]), 32'hF);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
